// File: rtl/acq_defs.sv
// Shared definitions for the acquisition peak sorter: peak-slot record,
// slot count, FSM state encoding and the exponent-alignment shift.
package acq_defs;

   localparam int PEAK_NUM = 3;

   typedef struct packed {
      logic [7:0] amp;
      logic [9:0] pos;
      logic [2:0] freq;
      logic [5:0] stride;
   } peak_slot_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FINAL   = 2'd2,
      ST_DONE    = 2'd3
   } acq_state_t;

   // Right shift with round-half-up; shifts of 8 or more flush to zero.
   function automatic logic [7:0] round_shift(input logic [7:0] amp, input logic [3:0] d);
      logic [8:0] sum;
      logic [2:0] idx;
      sum = {1'b0, amp};
      idx = 3'd0;
      if (d >= 4'd8) begin
         sum = 9'd0;
      end else if (d != 4'd0) begin
         idx = 3'(d - 4'd1);
         sum = {1'b0, amp >> d} + {8'd0, amp[idx]};
      end
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/acq_peak_insert.sv
// Combinational exponent alignment and sorted insert of one candidate into
// the peak slots. Neighbour exclusion is enabled by ACQ_PEAK_NEIGHBOR_EXCLUDE_EN.
module acq_peak_insert
   import acq_defs::*;
(
   input  logic       valid_i,
   input  peak_slot_t slots_i [PEAK_NUM],
   input  logic [3:0] exp_i,
   input  logic [7:0] amp_i,
   input  logic [3:0] cand_exp_i,
   input  logic [9:0] pos_i,
   input  logic [2:0] freq_i,
   input  logic [5:0] stride_i,
   output peak_slot_t slots_o [PEAK_NUM],
   output logic [3:0] exp_o
);

   peak_slot_t          aligned [PEAK_NUM];
   peak_slot_t          base    [PEAK_NUM];
   peak_slot_t          cand;
   logic [PEAK_NUM-1:0] gt;
   logic                ins;

   always_comb begin
      exp_o = exp_i;
      cand  = '{amp: amp_i, pos: pos_i, freq: freq_i, stride: stride_i};
      for (int i = 0; i < PEAK_NUM; i++) begin
         aligned[i] = slots_i[i];
      end
      if (valid_i) begin
         if (cand_exp_i > exp_i) begin
            exp_o = cand_exp_i;
            for (int i = 0; i < PEAK_NUM; i++) begin
               aligned[i].amp = round_shift(slots_i[i].amp, cand_exp_i - exp_i);
            end
         end else if (cand_exp_i < exp_i) begin
            cand.amp = round_shift(amp_i, exp_i - cand_exp_i);
         end
      end
   end

`ifdef ACQ_PEAK_NEIGHBOR_EXCLUDE_EN
   logic [PEAK_NUM-1:0] match;
   logic [PEAK_NUM-1:0] first_hit;
   logic [PEAK_NUM-1:0] vacated;
   logic [PEAK_NUM-1:0] gt_al;
   logic                win;

   // A neighbour may only replace its own slot; removing it lets the
   // ordinary insert below perform the re-sort.
   for (genvar gi = 0; gi < PEAK_NUM; gi++) begin : g_nbr
      assign match[gi] = (aligned[gi].amp != 8'd0) &&
                         (aligned[gi].freq == cand.freq) &&
                         (aligned[gi].stride == cand.stride) &&
                         (({1'b0, aligned[gi].pos} == {1'b0, cand.pos}) ||
                          ({1'b0, aligned[gi].pos} == {1'b0, cand.pos} + 11'd1) ||
                          ({1'b0, cand.pos} == {1'b0, aligned[gi].pos} + 11'd1));
      assign gt_al[gi] = cand.amp > aligned[gi].amp;
      if (gi == 0) begin : g_first
         assign first_hit[gi] = match[gi];
         assign vacated[gi]   = first_hit[gi];
      end else begin : g_rest
         assign first_hit[gi] = match[gi] & ~(|match[gi-1:0]);
         assign vacated[gi]   = vacated[gi-1] | first_hit[gi];
      end
      if (gi < PEAK_NUM - 1) begin : g_shift
         assign base[gi] = (win && vacated[gi]) ? aligned[gi+1] : aligned[gi];
      end else begin : g_last
         assign base[gi] = (win && vacated[gi]) ? peak_slot_t'('0) : aligned[gi];
      end
   end

   assign win = |(first_hit & gt_al);
   assign ins = valid_i && (cand.amp != 8'd0) && (!(|match) || win);
`else
   for (genvar gi = 0; gi < PEAK_NUM; gi++) begin : g_base
      assign base[gi] = aligned[gi];
   end

   assign ins = valid_i && (cand.amp != 8'd0);
`endif

   for (genvar gi = 0; gi < PEAK_NUM; gi++) begin : g_ins
      assign gt[gi] = ins && (cand.amp > base[gi].amp);
      if (gi == 0) begin : g_top
         assign slots_o[gi] = gt[gi] ? cand : base[gi];
      end else begin : g_low
         assign slots_o[gi] = gt[gi-1] ? base[gi-1] : (gt[gi] ? cand : base[gi]);
      end
   end

endmodule

// File: rtl/acq_peak_sort.sv
// Acquisition peak sorter: keeps the three strongest correlator candidates
// and a success flag. Define ACQ_PEAK_NEIGHBOR_EXCLUDE_EN for neighbour exclusion.
module acq_peak_sort
   import acq_defs::*;
(
   input  logic        clk,
   input  logic        rst_b,
   input  logic        search_start,
   input  logic        search_done,
   input  logic        noncoh_out_valid,
   input  logic [7:0]  noncoh_out_amp,
   input  logic [3:0]  noncoh_out_exp,
   input  logic [9:0]  noncoh_out_pos,
   input  logic [2:0]  noncoh_out_freq,
   input  logic [5:0]  stride_idx,
   input  logic [17:0] noise_floor,
   input  logic [3:0]  cor_num_log2,
   input  logic [5:0]  thresh_ratio,
   output logic [7:0]  peak_amp    [PEAK_NUM],
   output logic [9:0]  peak_pos    [PEAK_NUM],
   output logic [2:0]  peak_freq   [PEAK_NUM],
   output logic [5:0]  peak_stride [PEAK_NUM],
   output logic [3:0]  peak_exp,
   output logic [1:0]  peak_count,
   output logic        acq_success,
   output logic        peak_ready
);

   acq_state_t  state_q;
   peak_slot_t  slots_q [PEAK_NUM];
   peak_slot_t  slots_d [PEAK_NUM];
   logic [3:0]  exp_q, exp_d;
   logic [1:0]  count_q, count_d;
   logic        success_q, success_d;
   logic        ready_q;
   logic [17:0] mean_full;
   logic [7:0]  mean;
   logic [13:0] lhs, rhs;

   acq_peak_insert u_insert (
      .valid_i    (noncoh_out_valid && (state_q == ST_COLLECT) && !search_start),
      .slots_i    (slots_q),
      .exp_i      (exp_q),
      .amp_i      (noncoh_out_amp),
      .cand_exp_i (noncoh_out_exp),
      .pos_i      (noncoh_out_pos),
      .freq_i     (noncoh_out_freq),
      .stride_i   (stride_idx),
      .slots_o    (slots_d),
      .exp_o      (exp_d)
   );

   always_comb begin
      count_d = 2'd0;
      for (int i = 0; i < PEAK_NUM; i++) begin
         if (slots_d[i].amp != 8'd0) count_d = count_d + 2'd1;
      end
   end

   // Threshold: peak*4 against saturated mean times ratio (quarter units).
   always_comb begin
      mean_full = noise_floor >> cor_num_log2;
      mean      = (|mean_full[17:8]) ? 8'hFF : mean_full[7:0];
      lhs       = {4'd0, slots_q[0].amp, 2'b00};
      rhs       = 14'(mean) * 14'(thresh_ratio);
      success_d = (count_q != 2'd0) && (lhs >= rhs);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= ST_IDLE;
         exp_q     <= '0;
         count_q   <= '0;
         success_q <= 1'b0;
         ready_q   <= 1'b0;
         for (int i = 0; i < PEAK_NUM; i++) slots_q[i] <= '0;
      end else if (search_start) begin
         state_q   <= ST_COLLECT;
         exp_q     <= '0;
         count_q   <= '0;
         success_q <= 1'b0;
         ready_q   <= 1'b0;
         for (int i = 0; i < PEAK_NUM; i++) slots_q[i] <= '0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               slots_q <= slots_d;
               exp_q   <= exp_d;
               count_q <= count_d;
               if (search_done) state_q <= ST_FINAL;
            end
            ST_FINAL: begin
               success_q <= success_d;
               ready_q   <= 1'b1;
               state_q   <= ST_DONE;
            end
            default: ;
         endcase
      end
   end

   for (genvar gi = 0; gi < PEAK_NUM; gi++) begin : g_out
      assign peak_amp[gi]    = slots_q[gi].amp;
      assign peak_pos[gi]    = slots_q[gi].pos;
      assign peak_freq[gi]   = slots_q[gi].freq;
      assign peak_stride[gi] = slots_q[gi].stride;
   end

   assign peak_exp    = exp_q;
   assign peak_count  = count_q;
   assign acq_success = success_q;
   assign peak_ready  = ready_q;

endmodule

// File: tb/tb_acq_peak_sort.sv
// Self-checking bench for acq_peak_sort: threshold vector table, directed
// corner sequences and randomized runs against a queue-based reference model.
module tb_acq_peak_sort;
   import acq_defs::*;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        search_start = 1'b0, search_done = 1'b0, noncoh_out_valid = 1'b0;
   logic [7:0]  noncoh_out_amp = '0;
   logic [3:0]  noncoh_out_exp = '0;
   logic [9:0]  noncoh_out_pos = '0;
   logic [2:0]  noncoh_out_freq = '0;
   logic [5:0]  stride_idx = '0;
   logic [17:0] noise_floor = '0;
   logic [3:0]  cor_num_log2 = '0;
   logic [5:0]  thresh_ratio = '0;
   logic [7:0]  peak_amp    [PEAK_NUM];
   logic [9:0]  peak_pos    [PEAK_NUM];
   logic [2:0]  peak_freq   [PEAK_NUM];
   logic [5:0]  peak_stride [PEAK_NUM];
   logic [3:0]  peak_exp;
   logic [1:0]  peak_count;
   logic        acq_success, peak_ready;

   acq_peak_sort dut (
      .clk(clk), .rst_b(rst_b), .search_start(search_start), .search_done(search_done),
      .noncoh_out_valid(noncoh_out_valid), .noncoh_out_amp(noncoh_out_amp),
      .noncoh_out_exp(noncoh_out_exp), .noncoh_out_pos(noncoh_out_pos),
      .noncoh_out_freq(noncoh_out_freq), .stride_idx(stride_idx),
      .noise_floor(noise_floor), .cor_num_log2(cor_num_log2), .thresh_ratio(thresh_ratio),
      .peak_amp(peak_amp), .peak_pos(peak_pos), .peak_freq(peak_freq),
      .peak_stride(peak_stride), .peak_exp(peak_exp), .peak_count(peak_count),
      .acq_success(acq_success), .peak_ready(peak_ready)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {int amp; int pos; int freq; int stride;} pk_t;
   pk_t m_q[$];
   int  m_exp, m_state, m_success, m_ready;

   task automatic chk(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   function automatic int align_amp(input int amp, input int d);
      int v;
      if (d <= 0) return amp;
      if (d >= 8) return 0;
      v = (amp + (1 << (d - 1))) / (1 << d);
      return (v > 255) ? 255 : v;
   endfunction

   function automatic int m_count();
      int c = 0;
      foreach (m_q[i]) if (m_q[i].amp != 0) c++;
      return c;
   endfunction

   task automatic m_clear();
      pk_t z = '{0, 0, 0, 0};
      m_q = {};
      repeat (PEAK_NUM) m_q.push_back(z);
      m_exp = 0; m_success = 0; m_ready = 0;
   endtask

   task automatic m_accept(input int amp, input int ex, input int pos, input int fr, input int st);
      int  a = amp;
      pk_t c;
      if (ex > m_exp) begin
         foreach (m_q[i]) m_q[i].amp = align_amp(m_q[i].amp, ex - m_exp);
         m_exp = ex;
      end else if (ex < m_exp) begin
         a = align_amp(amp, m_exp - ex);
      end
      if (a == 0) return;
`ifdef ACQ_PEAK_NEIGHBOR_EXCLUDE_EN
      for (int k = 0; k < PEAK_NUM; k++) begin
         if (m_q[k].amp > 0 && m_q[k].freq == fr && m_q[k].stride == st &&
             pos - m_q[k].pos <= 1 && m_q[k].pos - pos <= 1) begin
            if (a <= m_q[k].amp) return;
            m_q.delete(k);
            m_q.push_back('{0, 0, 0, 0});
            break;
         end
      end
`endif
      c = '{a, pos, fr, st};
      for (int i = 0; i < PEAK_NUM; i++) begin
         if (a > m_q[i].amp) begin
            m_q.insert(i, c);
            m_q.delete(PEAK_NUM);
            return;
         end
      end
   endtask

   task automatic m_cycle(input int s, input int d, input int v, input int amp, input int ex,
                          input int pos, input int fr, input int st);
      int mean;
      if (s != 0) begin
         m_clear();
         m_state = 1;
         return;
      end
      case (m_state)
         1: begin
            if (v != 0) m_accept(amp, ex, pos, fr, st);
            if (d != 0) m_state = 2;
         end
         2: begin
            mean = int'(noise_floor >> cor_num_log2);
            if (mean > 255) mean = 255;
            m_success = (m_count() > 0 && m_q[0].amp * 4 >= mean * int'(thresh_ratio)) ? 1 : 0;
            m_ready = 1;
            m_state = 3;
         end
         default: ;
      endcase
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < PEAK_NUM; i++) begin
         chk($sformatf("%s amp%0d", tag, i), int'(peak_amp[i]), m_q[i].amp);
         chk($sformatf("%s pos%0d", tag, i), int'(peak_pos[i]), m_q[i].pos);
         chk($sformatf("%s freq%0d", tag, i), int'(peak_freq[i]), m_q[i].freq);
         chk($sformatf("%s stride%0d", tag, i), int'(peak_stride[i]), m_q[i].stride);
      end
      chk({tag, " exp"}, int'(peak_exp), m_exp);
      chk({tag, " count"}, int'(peak_count), m_count());
      chk({tag, " success"}, int'(acq_success), m_success);
      chk({tag, " ready"}, int'(peak_ready), m_ready);
   endtask

   // Drive one cycle at the falling edge, advance the model, check after the next fall.
   task automatic cyc(input string tag, input int s, input int d, input int v, input int amp,
                      input int ex, input int pos, input int fr, input int st);
      search_start = 1'(s); search_done = 1'(d); noncoh_out_valid = 1'(v);
      noncoh_out_amp = 8'(amp); noncoh_out_exp = 4'(ex); noncoh_out_pos = 10'(pos);
      noncoh_out_freq = 3'(fr); stride_idx = 6'(st);
      m_cycle(s, d, v, amp, ex, pos, fr, st);
      @(posedge clk);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   typedef struct {int nf; int lg; int ratio; int amp; int succ;} vec_t;
   vec_t tbl[9];

   initial begin
      tbl[0] = '{1600,   4, 12,  75, 0};
      tbl[1] = '{1600,   4,  8, 255, 1};
      tbl[2] = '{1600,   4,  1,  25, 1};
      tbl[3] = '{1600,   4,  1,  24, 0};
      tbl[4] = '{262143, 0, 63, 255, 0};
      tbl[5] = '{262143, 15, 63, 111, 1};
      tbl[6] = '{500,    0,  4, 255, 1};
      tbl[7] = '{1600,   4,  0,   0, 0};
      tbl[8] = '{1600,   4,  0,   1, 1};

      m_clear();
      m_state = 0;

      // Asynchronous reset state
      #2;
      chk("reset amp0", int'(peak_amp[0]), 0);
      chk("reset count", int'(peak_count), 0);
      chk("reset ready", int'(peak_ready), 0);
      chk("reset success", int'(acq_success), 0);
      @(negedge clk);
      rst_b = 1'b1;

      // Valid and done in IDLE are ignored
      cyc("idle valid", 0, 1, 1, 77, 0, 4, 0, 0);
      chk("idle ignore amp0", int'(peak_amp[0]), 0);

      // Sorted insert of 10,30,20 and ready two cycles after done
      cyc("r27 start", 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("r27 c1", 0, 0, 1, 10, 0, 1, 0, 0);
      cyc("r27 c2", 0, 0, 1, 30, 0, 2, 1, 0);
      cyc("r27 c3", 0, 0, 1, 20, 0, 3, 2, 0);
      cyc("r27 done", 0, 1, 0, 0, 0, 0, 0, 0);
      chk("r27 ready in final", int'(peak_ready), 0);
      idle("r27 final");
      chk("r27 ready", int'(peak_ready), 1);
      chk("r27 amp0", int'(peak_amp[0]), 30);
      chk("r27 pos0", int'(peak_pos[0]), 2);
      chk("r27 amp1", int'(peak_amp[1]), 20);
      chk("r27 pos1", int'(peak_pos[1]), 3);
      chk("r27 amp2", int'(peak_amp[2]), 10);
      chk("r27 pos2", int'(peak_pos[2]), 1);
      chk("r27 count", int'(peak_count), 3);
      cyc("r27 done ignored", 0, 1, 1, 200, 0, 9, 4, 0);
      chk("r27 stable amp0", int'(peak_amp[0]), 30);
      $display("seq r27 sorted insert done");

      // Exponent increase: stored amps rounded down, tie keeps old rank
      cyc("r28 start", 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("r28 c1", 0, 0, 1, 100, 2, 10, 0, 0);
      cyc("r28 c2", 0, 0, 1, 80, 2, 11, 1, 0);
      cyc("r28 c3", 0, 0, 1, 60, 2, 12, 2, 0);
      cyc("r28 c4", 0, 0, 1, 50, 3, 20, 3, 0);
      chk("r28 amp0", int'(peak_amp[0]), 50);
      chk("r28 pos0", int'(peak_pos[0]), 10);
      chk("r28 amp1", int'(peak_amp[1]), 50);
      chk("r28 pos1", int'(peak_pos[1]), 20);
      chk("r28 amp2", int'(peak_amp[2]), 40);
      chk("r28 exp", int'(peak_exp), 3);
      $display("seq r28 exponent realign done");

      // Candidate aligned down to a smaller exponent
      cyc("r29 start", 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("r29 c1", 0, 0, 1, 10, 2, 5, 0, 0);
      cyc("r29 c2", 0, 0, 1, 3, 0, 6, 1, 0);
      chk("r29 amp1", int'(peak_amp[1]), 1);
      chk("r29 pos1", int'(peak_pos[1]), 6);
      chk("r29 count", int'(peak_count), 2);
      cyc("r29 c3", 0, 0, 1, 1, 2, 9, 2, 0);
      chk("r29 amp2", int'(peak_amp[2]), 1);
      chk("r29 pos2", int'(peak_pos[2]), 9);
      cyc("r29 c4 tie", 0, 0, 1, 3, 0, 30, 3, 0);
      chk("r29 tie pos2", int'(peak_pos[2]), 9);
      chk("r29 count3", int'(peak_count), 3);
      $display("seq r29 candidate alignment done");

      // Start drops a coincident valid; reset mid-collect discards results
      cyc("r31 start", 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("r31 c1", 0, 0, 1, 50, 0, 1, 0, 0);
      cyc("r31 restart", 1, 0, 1, 200, 0, 2, 0, 0);
      chk("r31 amp0", int'(peak_amp[0]), 0);
      chk("r31 count", int'(peak_count), 0);
      cyc("r31 c2", 0, 0, 1, 40, 0, 3, 0, 0);
      rst_b = 1'b0;
      #1;
      chk("r31 rst amp0", int'(peak_amp[0]), 0);
      chk("r31 rst count", int'(peak_count), 0);
      chk("r31 rst ready", int'(peak_ready), 0);
      m_clear();
      m_state = 0;
      @(negedge clk);
      rst_b = 1'b1;
      cyc("r31 post reset", 0, 1, 1, 99, 0, 4, 0, 0);
      idle("r31 post reset2");
      chk("r31 idle ready", int'(peak_ready), 0);
      $display("seq r31 start/reset abort done");

      // Adjacent positions on the same freq/stride
      cyc("r32 start", 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("r32 c1", 0, 0, 1, 90, 0, 100, 1, 2);
      cyc("r32 c2", 0, 0, 1, 95, 0, 101, 1, 2);
      chk("r32 amp0", int'(peak_amp[0]), 95);
      chk("r32 pos0", int'(peak_pos[0]), 101);
`ifdef ACQ_PEAK_NEIGHBOR_EXCLUDE_EN
      chk("r32 count", int'(peak_count), 1);
      chk("r32 amp1", int'(peak_amp[1]), 0);
`else
      chk("r32 count", int'(peak_count), 2);
      chk("r32 amp1", int'(peak_amp[1]), 90);
      chk("r32 pos1", int'(peak_pos[1]), 100);
`endif
      $display("seq r32 neighbour handling done");

      // Threshold table: one candidate delivered together with done
      for (int t = 0; t < 9; t++) begin
         noise_floor = 18'(tbl[t].nf);
         cor_num_log2 = 4'(tbl[t].lg);
         thresh_ratio = 6'(tbl[t].ratio);
         cyc($sformatf("tbl%0d start", t), 1, 0, 0, 0, 0, 0, 0, 0);
         cyc($sformatf("tbl%0d cand", t), 0, 1, 1, tbl[t].amp, 0, 7, 0, 0);
         idle($sformatf("tbl%0d final", t));
         chk($sformatf("tbl%0d success", t), int'(acq_success), tbl[t].succ);
         chk($sformatf("tbl%0d amp0", t), int'(peak_amp[0]), tbl[t].amp);
         chk($sformatf("tbl%0d ready", t), int'(peak_ready), 1);
         $display("vec %0d nf=%0d lg=%0d ratio=%0d amp=%0d success=%0d",
                  t, tbl[t].nf, tbl[t].lg, tbl[t].ratio, tbl[t].amp, acq_success);
      end

      // Randomized searches against the reference model
      for (int r = 0; r < 30; r++) begin
         int n;
         noise_floor = 18'($urandom_range(0, 262143));
         cor_num_log2 = 4'($urandom_range(6, 12));
         thresh_ratio = 6'($urandom_range(0, 63));
         cyc($sformatf("rnd%0d start", r), 1, 0, 0, 0, 0, 0, 0, 0);
         n = int'($urandom_range(1, 14));
         for (int k = 0; k < n; k++) begin
            cyc($sformatf("rnd%0d c%0d", r, k), 0, (k == n - 1) ? 1 : 0,
                ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(1, 255)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
         end
         idle($sformatf("rnd%0d final", r));
         cyc($sformatf("rnd%0d done hold", r), 0, 1, 1, int'($urandom_range(1, 255)), 0, 3, 0, 0);
         $display("run %0d cands=%0d amp0=%0d count=%0d success=%0d",
                  r, n, peak_amp[0], peak_count, acq_success);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
